// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory access unit:
// op codes, dmem access-size codes and the transaction state encoding.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_e;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic [1:0] store_type(input mem_op_e op);
    case (op)
      OP_SW:   return DT_WORD;
      OP_SH:   return DT_HALF;
      default: return DT_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a memory word,
// and merges store data into a captured word for read-modify-write stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase

    case (op)
      OP_LW:   load_data = word;
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0000, half_sel};
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h000000, byte_sel};
      default: load_data = 32'h0;
    endcase
  end

  // Lanes not covered by the store keep the bytes read from memory.
  always_comb begin
    merged_word = word;
    case (op)
      OP_SW: merged_word = wdata;
      OP_SH: begin
        if (offset[1]) merged_word[31:16] = wdata[15:0];
        else           merged_word[15:0]  = wdata[15:0];
      end
      OP_SB: begin
        case (offset)
          2'd0:    merged_word[7:0]   = wdata[7:0];
          2'd1:    merged_word[15:8]  = wdata[7:0];
          2'd2:    merged_word[23:16] = wdata[7:0];
          default: merged_word[31:24] = wdata[7:0];
        endcase
      end
      default: merged_word = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-indexed data memory: one load/store per
// transaction, with sub-word stores at non-zero offsets done as read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WIDX_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_ena,
  output logic        dmem_wena,
  output logic [31:0] dmem_addr,
  output logic [1:0]  dmem_type,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  state_e      state;
  mem_op_e     op_q;
  logic [1:0]  offset_q;
  logic [31:0] wdata_q;

  mem_op_e     req_op_e;
  logic        accept;
  logic        req_err;
  logic        req_rmw;
  logic [31:0] req_widx;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_op_e = mem_op_e'(req_op);
  assign accept   = req_valid && req_ready;
  assign req_widx = {{(32 - WIDX_W){1'b0}}, req_addr[WIDX_W+1:2]};

  // Misalignment for the access size, or any address bit beyond the dmem range.
  always_comb begin
    req_err = (req_addr >> (WIDX_W + 2)) != 32'h0;
    case (req_op_e)
      OP_LW, OP_SW:         req_err = req_err || (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: req_err = req_err || req_addr[0];
      default:              req_err = req_err;
    endcase
    req_rmw = ((req_op_e == OP_SH) && req_addr[1]) ||
              ((req_op_e == OP_SB) && (req_addr[1:0] != 2'b00));
  end

  mem_lane_align u_align (
    .op          (op_q),
    .offset      (offset_q),
    .word        (dmem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // All outputs are registered: each transition loads the outputs of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_LW;
      offset_q   <= 2'b00;
      wdata_q    <= 32'h0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      dmem_ena   <= 1'b0;
      dmem_wena  <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_type  <= DT_WORD;
      dmem_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= req_op_e;
            offset_q  <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (!is_store(req_op_e) || req_rmw) begin
              state     <= ST_RD;
              dmem_ena  <= 1'b1;
              dmem_wena <= 1'b0;
              dmem_addr <= req_widx;
              dmem_type <= DT_WORD;
            end else begin
              state      <= ST_WR;
              dmem_ena   <= 1'b1;
              dmem_wena  <= 1'b1;
              dmem_addr  <= req_widx;
              dmem_type  <= store_type(req_op_e);
              dmem_wdata <= req_wdata;
            end
          end
        end
        ST_RD: begin
          if (is_store(op_q)) begin
            state      <= ST_WR;
            dmem_wena  <= 1'b1;
            dmem_type  <= DT_WORD;
            dmem_wdata <= merged_word;
          end else begin
            state      <= ST_RESP;
            dmem_ena   <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_type  <= DT_WORD;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
          end
        end
        ST_WR: begin
          state      <= ST_RESP;
          dmem_ena   <= 1'b0;
          dmem_wena  <= 1'b0;
          dmem_addr  <= 32'h0;
          dmem_type  <= DT_WORD;
          dmem_wdata <= 32'h0;
          resp_valid <= 1'b1;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a behavioural dmem plus a byte-level
// reference memory, directed scenarios and randomized load/store traffic.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_ena;
  logic        dmem_wena;
  logic [31:0] dmem_addr;
  logic [1:0]  dmem_type;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  int checks;
  int failures;

  logic [31:0] dmem [0:2047];
  logic [7:0]  ref_mem [0:8191];
  int          wr_count;
  logic [31:0] last_wr_addr;
  logic [1:0]  last_wr_type;

  mem_access_unit #(.WIDX_W(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dmem_ena   (dmem_ena),
    .dmem_wena  (dmem_wena),
    .dmem_addr  (dmem_addr),
    .dmem_type  (dmem_type),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmem: combinational read, write on negedge, sized by dmem_type.
  assign dmem_rdata = (dmem_addr < 32'd2048) ? dmem[dmem_addr[10:0]] : 32'h0;

  always @(negedge clk) begin
    if (dmem_ena && dmem_wena && dmem_addr < 32'd2048) begin
      case (dmem_type)
        2'b00:   dmem[dmem_addr[10:0]]        = dmem_wdata;
        2'b01:   dmem[dmem_addr[10:0]][15:0]  = dmem_wdata[15:0];
        default: dmem[dmem_addr[10:0]][7:0]   = dmem_wdata[7:0];
      endcase
      wr_count     = wr_count + 1;
      last_wr_addr = dmem_addr;
      last_wr_type = dmem_type;
    end
  end

  // Reference model over a byte-addressed memory.
  function automatic int op_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd5) return 4;
    if (op == 3'd1 || op == 3'd2 || op == 3'd6) return 2;
    return 1;
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return op >= 3'd5;
  endfunction

  function automatic logic ref_err(input logic [2:0] op, input logic [31:0] addr);
    return (addr >= 32'h2000) || ((addr % op_size(op)) != 0);
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] addr);
    if (ref_err(op, addr)) return 1;
    if (!op_is_store(op)) return 2;
    return (addr % 4 == 0) ? 2 : 3;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < op_size(op); i++) v[8*i +: 8] = ref_mem[addr + i];
    if (op == 3'd1) v = {{16{v[15]}}, v[15:0]};
    if (op == 3'd3) v = {{24{v[7]}}, v[7:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < op_size(op); i++) ref_mem[addr + i] = wdata[8*i +: 8];
  endtask

  // Issues one request and follows it to its response, keeping the model in step.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic ena_seen);
    int wait_cnt;
    rdata = 32'h0;
    err = 1'b0;
    lat = -1;
    ena_seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("[TB] FAIL txn_ready: req_ready=%0b required 1", req_ready);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (dmem_ena) ena_seen = 1'b1;
      if (resp_valid) begin
        rdata = resp_rdata;
        err   = resp_err;
        lat   = k;
        break;
      end
    end
    if (!ref_err(op, addr) && op_is_store(op)) ref_store(op, addr, wdata);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %0b required 1", req_ready);
    end
    checks++;
    if ({resp_valid, resp_err, dmem_ena, dmem_wena} !== 4'b0000 || resp_rdata !== 32'h0 ||
        dmem_addr !== 32'h0 || dmem_type !== 2'b00 || dmem_wdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: rv=%0b err=%0b ena=%0b wena=%0b rdata=%h addr=%h type=%0d wdata=%h required all 0",
               resp_valid, resp_err, dmem_ena, dmem_wena, resp_rdata, dmem_addr, dmem_type, dmem_wdata);
    end
  endtask

  task automatic test_word_access();
    logic [31:0] rd; logic er; int lat; logic ena; int wc;
    wc = wr_count;
    run_txn(3'd5, 32'h10, 32'hDEADBEEF, rd, er, lat, ena);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL sw_resp: lat=%0d err=%0b rdata=%h required lat=2 err=0 rdata=0", lat, er, rd);
    end
    checks++;
    if (wr_count - wc !== 1 || last_wr_addr !== 32'd4 || last_wr_type !== 2'b00) begin
      failures++;
      $display("[TB] FAIL sw_dmem: writes=%0d addr=%h type=%0d required 1 write addr=4 type=0",
               wr_count - wc, last_wr_addr, last_wr_type);
    end
    run_txn(3'd0, 32'h10, 32'h0, rd, er, lat, ena);
    checks++;
    if (rd !== 32'hDEADBEEF || lat !== 2 || er !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lw_resp: rdata=%h lat=%0d err=%0b required DEADBEEF lat=2 err=0", rd, lat, er);
    end
  endtask

  task automatic test_rmw_store();
    logic [31:0] rd; logic er; int lat; logic ena; int wc;
    wc = wr_count;
    run_txn(3'd7, 32'h11, 32'h000000AA, rd, er, lat, ena);
    checks++;
    if (lat !== 3 || dmem[4] !== 32'hDEADAAEF || wr_count - wc !== 1 || last_wr_type !== 2'b00) begin
      failures++;
      $display("[TB] FAIL sb_rmw: lat=%0d word=%h writes=%0d type=%0d required lat=3 DEADAAEF 1 type 0",
               lat, dmem[4], wr_count - wc, last_wr_type);
    end
    run_txn(3'd4, 32'h11, 32'h0, rd, er, lat, ena);
    checks++;
    if (rd !== 32'h000000AA) begin
      failures++;
      $display("[TB] FAIL lbu_rmw: got %h required 000000AA", rd);
    end
    run_txn(3'd3, 32'h11, 32'h0, rd, er, lat, ena);
    checks++;
    if (rd !== 32'hFFFFFFAA) begin
      failures++;
      $display("[TB] FAIL lb_rmw: got %h required FFFFFFAA", rd);
    end
    run_txn(3'd6, 32'h12, 32'h00008001, rd, er, lat, ena);
    checks++;
    if (lat !== 3 || dmem[4] !== 32'h8001AAEF) begin
      failures++;
      $display("[TB] FAIL sh_rmw: lat=%0d word=%h required lat=3 8001AAEF", lat, dmem[4]);
    end
    run_txn(3'd1, 32'h12, 32'h0, rd, er, lat, ena);
    checks++;
    if (rd !== 32'hFFFF8001) begin
      failures++;
      $display("[TB] FAIL lh_rmw: got %h required FFFF8001", rd);
    end
    run_txn(3'd2, 32'h12, 32'h0, rd, er, lat, ena);
    checks++;
    if (rd !== 32'h00008001) begin
      failures++;
      $display("[TB] FAIL lhu_rmw: got %h required 00008001", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; logic ena; int wc;
    logic [2:0]  ops   [3];
    logic [31:0] addrs [3];
    ops   = '{3'd0, 3'd6, 3'd3};
    addrs = '{32'h13, 32'h15, 32'h2000};
    for (int i = 0; i < 3; i++) begin
      wc = wr_count;
      run_txn(ops[i], addrs[i], 32'h12345678, rd, er, lat, ena);
      checks++;
      if (er !== 1'b1 || lat !== 1 || ena !== 1'b0 || rd !== 32'h0 || wr_count !== wc) begin
        failures++;
        $display("[TB] FAIL error_%0d: err=%0b lat=%0d ena_seen=%0b rdata=%h writes=%0d required err=1 lat=1 no access",
                 i, er, lat, ena, rd, wr_count - wc);
      end
    end
  endtask

  task automatic test_reset_mid_txn();
    logic saw_resp;
    int wc;
    wc = wr_count;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_addr  = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (dmem_ena !== 1'b1 || dmem_wena !== 1'b0 || dmem_addr !== 32'd4) begin
      failures++;
      $display("[TB] FAIL rst_mid_rd: ena=%0b wena=%0b addr=%h required 1 0 4", dmem_ena, dmem_wena, dmem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dmem_ena !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid_state: rv=%0b ready=%0b ena=%0b required 0 1 0", resp_valid, req_ready, dmem_ena);
    end
    saw_resp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid || dmem_ena) saw_resp = 1'b1;
    end
    checks++;
    if (saw_resp !== 1'b0 || wr_count !== wc) begin
      failures++;
      $display("[TB] FAIL rst_mid_quiet: activity=%0b writes=%0d required none", saw_resp, wr_count - wc);
    end
  endtask

  task automatic test_back_to_back();
    int n, first_resp, second_resp, ready_n;
    logic [31:0] first_rd, second_rd, data;
    data = $urandom;
    first_resp = 0; second_resp = 0; ready_n = 0;
    first_rd = 32'hX; second_rd = 32'hX;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd5;
    req_addr  = 32'h40;
    req_wdata = data;
    n = 0;
    while (n < 12 && second_resp == 0) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_op   = 3'd0;
        req_addr = 32'h40;
      end
      if (resp_valid) begin
        if (first_resp == 0) begin
          first_resp = n;
          first_rd = resp_rdata;
        end else begin
          second_resp = n;
          second_rd = resp_rdata;
        end
      end
      if (req_ready && ready_n == 0) ready_n = n;
      if (ready_n != 0 && n == ready_n + 1) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    ref_store(3'd5, 32'h40, data);
    checks++;
    if (first_resp !== 2 || first_rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL b2b_first: resp_cycle=%0d rdata=%h required 2 0", first_resp, first_rd);
    end
    checks++;
    if (ready_n !== 3) begin
      failures++;
      $display("[TB] FAIL b2b_accept: ready_cycle=%0d required 3", ready_n);
    end
    checks++;
    if (second_resp !== 5 || second_rd !== ref_load(3'd0, 32'h40)) begin
      failures++;
      $display("[TB] FAIL b2b_second: resp_cycle=%0d rdata=%h required 5 %h",
               second_resp, second_rd, ref_load(3'd0, 32'h40));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wdata; logic er, exp_er; int lat, exp_lat; logic ena;
    logic [2:0] op;
    for (int t = 0; t < 250; t++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = 32'h100 + 32'($urandom_range(0, 255));
      wdata   = $urandom;
      exp_er  = ref_err(op, addr);
      exp_lat = ref_latency(op, addr);
      exp_rd  = (exp_er || op_is_store(op)) ? 32'h0 : ref_load(op, addr);
      run_txn(op, addr, wdata, rd, er, lat, ena);
      checks++;
      if (er !== exp_er || lat !== exp_lat || rd !== exp_rd || (exp_er && ena)) begin
        failures++;
        $display("[TB] FAIL random_%0d op=%0d addr=%h: err=%0b lat=%0d rdata=%h ena_seen=%0b required err=%0b lat=%0d rdata=%h",
                 t, op, addr, er, lat, rd, ena, exp_er, exp_lat, exp_rd);
      end
    end
    for (int w = 32'h40; w < 32'h80; w++) begin
      checks++;
      if (dmem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) begin
        failures++;
        $display("[TB] FAIL mem_word_%0h: got %h required %h", w, dmem[w],
                 {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    wr_count = 0;
    last_wr_addr = 32'h0;
    last_wr_type = 2'b00;
    for (int i = 0; i < 2048; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_word_access();
    test_rmw_store();
    test_errors();
    test_reset_mid_txn();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
